p4_operand_fetch: RTL and testbench
===================================

Name: p4_operand_fetch

Overview:
- Operand-fetch stage directly upstream of the datapath shifter.
- Holds the 8x16 register file (one read port, one write port) and sequences two reads through the single read port: Rn into the A latch, then Rm into the B latch.
- Presents A, B and the requested shift code with a valid/ready handshake.
- b_out and shift_out drive the shifter's in and shift inputs; a_out goes to the ALU's A side.

Parameters:
- DATA_W, 16, register and operand width.
- REG_CNT, 8, number of registers; ADDR_W = log2(REG_CNT) = 3.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request an operand fetch; sampled only when the block can accept
- rn  in  ADDR_W  register index for A
- rm  in  ADDR_W  register index for B
- shift_in  in  2  shift code to forward (00 none, 01 LSL1, 10 LSR1, 11 ASR1)
- busy  out  1  high in READ_A and READ_B
- valid  out  1  operands available (HOLD state)
- ready  in  1  downstream accepts the operands
- a_out  out  DATA_W  latched value of Rn
- b_out  out  DATA_W  latched value of Rm, to shifter in
- shift_out  out  2  latched shift_in, to shifter shift
- write  in  1  register-file write enable
- writenum  in  ADDR_W  write index
- data_in  in  DATA_W  write data

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; a_out=b_out=0; shift_out=00; valid=0; busy=0; all registers=0.
  - A write in the reset cycle is discarded.
  - Reset mid-fetch aborts the fetch with no partial output.
- FSM states: IDLE, READ_A, READ_B, HOLD.
- IDLE:
  - If start=1, capture rn, rm, shift_in into internal regs at the edge, then go to READ_A.
  - Otherwise stay in IDLE.
- READ_A: readnum=rn_q; at the edge, A<=regfile[rn_q]; go to READ_B.
- READ_B:
  - readnum=rm_q; at the edge, B<=regfile[rm_q] and shift_out<=shift_q; go to HOLD.
- HOLD:
  - valid=1; a_out, b_out and shift_out are held stable.
  - If ready=0, stay in HOLD.
  - If ready=1 and start=0, go to IDLE.
  - If ready=1 and start=1, capture the new request and go directly to READ_A (back-to-back issue).
- Start acceptance:
  - start is ignored in READ_A and READ_B, and in HOLD when ready=0.
  - A dropped request is not queued.
- Latency: start high in cycle 0 gives valid=1 from cycle 3. Sustained throughput is one operand pair per 3 cycles.
- valid is a registered output, equal to (state==HOLD).
- busy is a registered output, equal to (state==READ_A or READ_B).
- Write port:
  - Independent of the FSM and active in every state; regfile[writenum]<=data_in at the edge when write=1.
  - There is no bypass: a read of the register being written in the same cycle captures the old value; the new value is visible from the next cycle.
- rn==rm is legal; A and B receive the same value unless a write lands between the two read cycles.
- a_out and b_out change only at the READ_A and READ_B edges and at reset. Register writes after the B latch do not disturb outputs in HOLD.

Decomposition:
- Shared package holds:
  - DATA_W and ADDR_W constants.
  - FSM state encoding: IDLE=2'd0, READ_A=2'd1, READ_B=2'd2, HOLD=2'd3.
  - Shift code constants SH_NONE, SH_LSL1, SH_LSR1, SH_ASR1, shared with the shifter.
- One sub-module: p4_regfile.
  - Inputs: clk, reset, write, writenum, data_in, readnum.
  - Output: data_out, combinational read.
  - Writes happen on the clock edge.

Test Plan:
- Reset then idle: assert reset 2 cycles -> a_out=0, b_out=0, shift_out=00, valid=0, busy=0; a fetch of r0,r7 returns 0,0.
- Basic fetch: write r2=0x1234, r5=0xF00F; start with rn=2, rm=5, shift=11 in cycle 0 -> busy in cycles 1–2; valid from cycle 3 with a_out=0x1234, b_out=0xF00F, shift_out=11.
- Backpressure and back-to-back: hold ready=0 for 4 cycles -> outputs stable, start ignored.
  - Then ready=1 with start (rn=5, rm=2) -> next valid 3 cycles later with a_out=0xF00F, b_out=0x1234.
- Write/read collision: in the READ_B cycle, write rm=0xAAAA -> b_out equals the old value; the next fetch of the same register returns 0xAAAA.
- Reset mid-operation: assert reset while in READ_B -> next cycle IDLE, valid=0, b_out=0, all registers 0.
- Start while busy: pulse start in READ_A with rn=1 -> ignored; the original operands are delivered and no second valid follows.

Source files
------------

// File: rtl/p4_operand_fetch_pkg.sv
// Shared constants for the operand-fetch stage and the shifter it feeds.
// Holds operand widths, FSM encoding and the shift codes.
package p4_operand_fetch_pkg;

  localparam int DATA_W  = 16;
  localparam int REG_CNT = 8;
  localparam int ADDR_W  = $clog2(REG_CNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ_A = 2'd1,
    READ_B = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL1 = 2'b01;
  localparam logic [1:0] SH_LSR1 = 2'b10;
  localparam logic [1:0] SH_ASR1 = 2'b11;

endpackage

// File: rtl/p4_regfile.sv
// 8x16 register file: one clocked write port, one combinational read port.
// Read latency 0; write visible the cycle after the edge (no bypass).
// No backpressure; reset clears every entry and drops a coincident write.
module p4_regfile
  import p4_operand_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] writenum,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] readnum,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] regs [REG_CNT];

  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '{default: '0};
    end else if (write) begin
      regs[writenum] <= data_in;
    end
  end

  assign data_out = regs[readnum];

endmodule

// File: rtl/p4_operand_fetch.sv
// Operand fetch: reads Rn then Rm through one read port and presents A/B/shift.
// Latency: start in cycle 0 gives valid from cycle 3; one pair per 3 cycles.
// Backpressure: HOLD keeps outputs stable until ready; start is dropped unless accepted.
module p4_operand_fetch
  import p4_operand_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] rn,
  input  logic [ADDR_W-1:0] rm,
  input  logic [1:0]        shift_in,
  output logic              busy,
  output logic              valid,
  input  logic              ready,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [1:0]        shift_out,
  input  logic              write,
  input  logic [ADDR_W-1:0] writenum,
  input  logic [DATA_W-1:0] data_in
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rn_q, rm_q, readnum;
  logic [1:0]          shift_q;
  logic [DATA_W-1:0]   rd_data;
  logic                accept;

  p4_regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .write    (write),
    .writenum (writenum),
    .data_in  (data_in),
    .readnum  (readnum),
    .data_out (rd_data)
  );

  always_comb begin
    state_d = state_q;
    readnum = rn_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = READ_A;
        end
      end
      READ_A: state_d = READ_B;
      READ_B: begin
        readnum = rm_q;
        state_d = HOLD;
      end
      HOLD: begin
        // A new request is only taken in the same cycle the current pair retires.
        if (ready) begin
          if (start) begin
            accept  = 1'b1;
            state_d = READ_A;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      valid     <= 1'b0;
      busy      <= 1'b0;
      rn_q      <= '0;
      rm_q      <= '0;
      shift_q   <= SH_NONE;
      a_out     <= '0;
      b_out     <= '0;
      shift_out <= SH_NONE;
    end else begin
      state_q <= state_d;
      valid   <= (state_d == HOLD);
      busy    <= (state_d == READ_A) || (state_d == READ_B);
      if (accept) begin
        rn_q    <= rn;
        rm_q    <= rm;
        shift_q <= shift_in;
      end
      if (state_q == READ_A) begin
        a_out <= rd_data;
      end
      if (state_q == READ_B) begin
        b_out     <= rd_data;
        shift_out <= shift_q;
      end
    end
  end

endmodule

// File: tb/tb_p4_operand_fetch.sv
// Directed bench for p4_operand_fetch with hand-computed expectations.
module tb_p4_operand_fetch;
  import p4_operand_fetch_pkg::*;

  logic              clk = 1'b0;
  logic              reset, start, ready, write;
  logic [ADDR_W-1:0] rn, rm, writenum;
  logic [1:0]        shift_in, shift_out;
  logic [DATA_W-1:0] data_in, a_out, b_out;
  logic              busy, valid;

  int errors = 0;
  int checks = 0;

  p4_operand_fetch dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rn        (rn),
    .rm        (rm),
    .shift_in  (shift_in),
    .busy      (busy),
    .valid     (valid),
    .ready     (ready),
    .a_out     (a_out),
    .b_out     (b_out),
    .shift_out (shift_out),
    .write     (write),
    .writenum  (writenum),
    .data_in   (data_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] n, input logic [DATA_W-1:0] d);
    write = 1'b1; writenum = n; data_in = d;
    step();
    write = 1'b0;
  endtask

  // Issue from IDLE and walk to HOLD, checking busy/valid each cycle.
  task automatic fetch(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                       input logic [1:0] sh, input string tag);
    start = 1'b1; rn = a; rm = b; shift_in = sh;
    step();
    start = 1'b0;
    chk({tag, "_busy1"}, busy, 1);
    chk({tag, "_valid1"}, valid, 0);
    step();
    chk({tag, "_busy2"}, busy, 1);
    step();
    chk({tag, "_valid3"}, valid, 1);
    chk({tag, "_busy3"}, busy, 0);
  endtask

  task automatic retire(input string tag);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk({tag, "_retired"}, valid, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ready = 1'b0; write = 1'b0;
    rn = '0; rm = '0; writenum = '0; shift_in = 2'b00; data_in = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_a", a_out, 0);
    chk("rst_b", b_out, 0);
    chk("rst_sh", shift_out, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);

    fetch(3'd0, 3'd7, SH_NONE, "r0r7");
    chk("r0r7_a", a_out, 0);
    chk("r0r7_b", b_out, 0);
    retire("r0r7");

    // Basic fetch
    wr(3'd2, 16'h1234);
    wr(3'd5, 16'hF00F);
    fetch(3'd2, 3'd5, SH_ASR1, "basic");
    chk("basic_a", a_out, 16'h1234);
    chk("basic_b", b_out, 16'hF00F);
    chk("basic_sh", shift_out, 2'b11);

    // Backpressure: start ignored while ready=0
    start = 1'b1; rn = 3'd1; rm = 3'd1; shift_in = SH_LSR1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_valid", valid, 1);
      chk("bp_busy", busy, 0);
      chk("bp_a", a_out, 16'h1234);
      chk("bp_b", b_out, 16'hF00F);
      chk("bp_sh", shift_out, 2'b11);
    end

    // Back-to-back issue on retirement
    ready = 1'b1; rn = 3'd5; rm = 3'd2; shift_in = SH_LSL1;
    step();
    ready = 1'b0; start = 1'b0;
    chk("b2b_busy1", busy, 1);
    chk("b2b_valid1", valid, 0);
    step();
    chk("b2b_busy2", busy, 1);
    step();
    chk("b2b_valid3", valid, 1);
    chk("b2b_a", a_out, 16'hF00F);
    chk("b2b_b", b_out, 16'h1234);
    chk("b2b_sh", shift_out, 2'b01);
    retire("b2b");

    // Write to rm during READ_B captures the old value
    start = 1'b1; rn = 3'd3; rm = 3'd4; shift_in = SH_NONE;
    step();
    start = 1'b0;
    step();
    chk("coll_busy_rb", busy, 1);
    write = 1'b1; writenum = 3'd4; data_in = 16'hAAAA;
    step();
    write = 1'b0;
    chk("coll_valid", valid, 1);
    chk("coll_b_old", b_out, 16'h0000);
    wr(3'd4, 16'h5555);
    chk("hold_b_stable", b_out, 16'h0000);
    retire("coll");
    wr(3'd4, 16'hAAAA);
    fetch(3'd4, 3'd4, SH_LSR1, "coll2");
    chk("coll2_a", a_out, 16'hAAAA);
    chk("coll2_b", b_out, 16'hAAAA);
    retire("coll2");

    // Reset during READ_B; coincident write is discarded
    start = 1'b1; rn = 3'd2; rm = 3'd5; shift_in = SH_ASR1;
    step();
    start = 1'b0;
    step();
    reset = 1'b1; write = 1'b1; writenum = 3'd6; data_in = 16'hBEEF;
    step();
    reset = 1'b0; write = 1'b0;
    chk("mid_valid", valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_a", a_out, 0);
    chk("mid_b", b_out, 0);
    chk("mid_sh", shift_out, 0);
    step();
    chk("mid_idle_valid", valid, 0);
    fetch(3'd2, 3'd6, SH_NONE, "postrst");
    chk("postrst_a", a_out, 0);
    chk("postrst_b", b_out, 0);
    retire("postrst");

    // Start while busy is dropped, not queued
    wr(3'd1, 16'h1111);
    wr(3'd2, 16'h2222);
    wr(3'd3, 16'h3333);
    start = 1'b1; rn = 3'd2; rm = 3'd3; shift_in = SH_LSL1;
    step();
    rn = 3'd1; rm = 3'd1; shift_in = SH_LSR1;
    step();
    start = 1'b0;
    step();
    chk("sb_valid", valid, 1);
    chk("sb_a", a_out, 16'h2222);
    chk("sb_b", b_out, 16'h3333);
    chk("sb_sh", shift_out, 2'b01);
    retire("sb");
    for (int i = 0; i < 4; i++) begin
      step();
      chk("sb_no_valid", valid, 0);
      chk("sb_no_busy", busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
